// File: rtl/usb_pkg.sv
// Shared types and constants for the USB full-speed receive path.
package usb_pkg;

  // Receive packet FSM states
  typedef enum logic [2:0] {
    RX_IDLE  = 3'd0,
    RX_PID   = 3'd1,
    RX_TOKEN = 3'd2,
    RX_HS    = 3'd3,
    RX_DATA  = 3'd4,
    RX_DONE  = 3'd5,
    RX_ERR   = 3'd6
  } rx_state_t;

  // PID bytes as presented by the deserializer
  localparam logic [7:0] PID_OUT   = 8'hE1;
  localparam logic [7:0] PID_IN    = 8'h69;
  localparam logic [7:0] PID_DATA0 = 8'hC3;
  localparam logic [7:0] PID_DATA1 = 8'h4B;
  localparam logic [7:0] PID_ACK   = 8'hD2;
  localparam logic [7:0] PID_NAK   = 8'h5A;
  localparam logic [7:0] PID_STALL = 8'h1E;

  // rx_packet report codes
  localparam logic [2:0] PKT_NONE  = 3'd0;
  localparam logic [2:0] PKT_OUT   = 3'd1;
  localparam logic [2:0] PKT_IN    = 3'd2;
  localparam logic [2:0] PKT_DATA0 = 3'd3;
  localparam logic [2:0] PKT_DATA1 = 3'd4;
  localparam logic [2:0] PKT_ACK   = 3'd5;
  localparam logic [2:0] PKT_NAK   = 3'd6;
  localparam logic [2:0] PKT_STALL = 3'd7;

  localparam logic [7:0] SYNC_VAL_DEFAULT = 8'h80;

  // Reflected CRC16; running the register over payload plus the
  // transmitted (inverted) CRC leaves this fixed residual.
  localparam logic [15:0] CRC16_POLY     = 16'hA001;
  localparam logic [15:0] CRC16_INIT     = 16'hFFFF;
  localparam logic [15:0] CRC16_RESIDUAL = 16'hB001;

  // Map a PID byte to its report code; PKT_NONE when the check nibble
  // is wrong or the PID is not one this receiver understands.
  function automatic logic [2:0] pid_decode(input logic [7:0] pid);
    logic [2:0] code;
    code = PKT_NONE;
    if (pid[7:4] == ~pid[3:0]) begin
      case (pid)
        PID_OUT:   code = PKT_OUT;
        PID_IN:    code = PKT_IN;
        PID_DATA0: code = PKT_DATA0;
        PID_DATA1: code = PKT_DATA1;
        PID_ACK:   code = PKT_ACK;
        PID_NAK:   code = PKT_NAK;
        PID_STALL: code = PKT_STALL;
        default:   code = PKT_NONE;
      endcase
    end
    return code;
  endfunction

  function automatic logic pkt_is_token(input logic [2:0] code);
    return (code == PKT_OUT) || (code == PKT_IN);
  endfunction

  function automatic logic pkt_is_data(input logic [2:0] code);
    return (code == PKT_DATA0) || (code == PKT_DATA1);
  endfunction

  // One byte through the reflected CRC16, LSB first as on the wire
  function automatic logic [15:0] crc16_update(input logic [15:0] crc, input logic [7:0] data);
    logic [15:0] c;
    c = crc;
    for (int i = 0; i < 8; i++) begin
      if (c[0] ^ data[i]) c = (c >> 1) ^ CRC16_POLY;
      else                c = c >> 1;
    end
    return c;
  endfunction

endpackage

// File: rtl/usb_crc16_check.sv
// Running CRC16 over data-packet bytes, one byte per cycle.
// o_crc_ok reflects the register value including any byte presented
// this cycle, so a byte arriving together with EOP is already counted.
module usb_crc16_check
  import usb_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_clear,
  input  logic       i_byte_en,
  input  logic [7:0] i_byte,
  output logic       o_crc_ok
);

  logic [15:0] r_crc;
  logic [15:0] w_crc_next;

  // Next CRC value: seed on clear, fold in a byte when enabled
  always_comb begin
    w_crc_next = r_crc;
    if (i_clear)        w_crc_next = CRC16_INIT;
    else if (i_byte_en) w_crc_next = crc16_update(r_crc, i_byte);
  end

  // CRC register
  always_ff @(posedge i_clk) begin
    if (i_rst) r_crc <= '0;
    else       r_crc <= w_crc_next;
  end

  assign o_crc_ok = (w_crc_next == CRC16_RESIDUAL);

endmodule

// File: rtl/usb_rx_controller.sv
// USB full-speed receive packet FSM: SYNC/PID validation, token and
// handshake framing, data payload forwarding through a 2-byte hold
// pipeline so the trailing CRC bytes never reach the RX FIFO.
module usb_rx_controller
  import usb_pkg::*;
#(
  parameter int         MAX_PAYLOAD = 64,
  parameter int         BUF_DEPTH   = 64,
  parameter logic [7:0] SYNC_VAL    = SYNC_VAL_DEFAULT
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_byte_ready,
  input  logic [7:0] i_rx_byte,
  input  logic       i_eop,
  input  logic       i_stuff_error,
  input  logic [6:0] i_buffer_occupancy,
  output logic [2:0] o_rx_packet,
  output logic       o_rx_data_ready,
  output logic       o_rx_transfer_active,
  output logic       o_rx_error,
  output logic       o_store_rx_packet_data,
  output logic [7:0] o_rx_packet_data,
  output logic       o_rx_flush
);

  rx_state_t r_state;
  rx_state_t w_state_next;

  // Output registers
  logic [2:0] r_packet;
  logic       r_data_ready;
  logic       r_active;
  logic       r_error;
  logic       r_store;
  logic [7:0] r_pdata;
  logic       r_flush;

  // Datapath registers
  logic [7:0] r_hold0;      // oldest held byte
  logic [7:0] r_hold1;      // newest held byte
  logic [1:0] r_hold_cnt;   // bytes held, saturates at 2
  logic [1:0] r_tok_cnt;    // token bytes seen, saturates at 2
  logic [6:0] r_pay_cnt;    // payload bytes written
  logic       r_is_data;    // current packet is DATA0/DATA1

  // Decode / event wires
  logic [2:0] w_pid_code;
  logic       w_sync_ok;
  logic       w_pid_ok;
  logic       w_write_due;
  logic       w_write;
  logic       w_err;
  logic       w_fin_err;
  logic       w_is_data;
  logic       w_full;
  logic       w_crc_ok;
  logic       w_crc_clear;
  logic       w_crc_en;
  logic [1:0] w_hold_after;
  logic [1:0] w_tok_after;

  // Next-cycle output values
  logic [2:0] w_packet_next;
  logic       w_data_ready_next;
  logic       w_active_next;
  logic       w_error_next;
  logic       w_store_next;
  logic [7:0] w_pdata_next;
  logic       w_flush_next;

  assign w_pid_code   = pid_decode(i_rx_byte);
  assign w_full       = (i_buffer_occupancy == 7'(BUF_DEPTH));
  assign w_hold_after = (i_byte_ready && (r_hold_cnt != 2'd2)) ? r_hold_cnt + 2'd1 : r_hold_cnt;
  assign w_tok_after  = (i_byte_ready && (r_tok_cnt != 2'd2)) ? r_tok_cnt + 2'd1 : r_tok_cnt;
  assign w_crc_clear  = w_pid_ok && pkt_is_data(w_pid_code);
  assign w_crc_en     = (r_state == RX_DATA) && i_byte_ready && !i_stuff_error;
  assign w_write      = w_write_due && !w_err;
  // The packet type that a flush decision should use, including a PID latched this cycle
  assign w_is_data    = w_pid_ok ? pkt_is_data(w_pid_code) : r_is_data;

  usb_crc16_check u_crc (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_clear   (w_crc_clear),
    .i_byte_en (w_crc_en),
    .i_byte    (i_rx_byte),
    .o_crc_ok  (w_crc_ok)
  );

  // State register
  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= RX_IDLE;
    else       r_state <= w_state_next;
  end

  // Next-state logic; an error seen together with EOP finishes the packet at once
  always_comb begin
    w_state_next = r_state;
    w_sync_ok    = 1'b0;
    w_pid_ok     = 1'b0;
    w_write_due  = 1'b0;
    w_err        = 1'b0;
    w_fin_err    = 1'b0;
    case (r_state)
      RX_IDLE: begin
        if (i_byte_ready && (i_rx_byte == SYNC_VAL)) begin
          w_sync_ok    = 1'b1;
          w_state_next = RX_PID;
        end
      end
      RX_PID: begin
        if (i_stuff_error) begin
          w_err = 1'b1;
        end else if (i_byte_ready) begin
          if (w_pid_code == PKT_NONE) begin
            w_err = 1'b1;
          end else begin
            w_pid_ok = 1'b1;
            if (pkt_is_token(w_pid_code))     w_state_next = RX_TOKEN;
            else if (pkt_is_data(w_pid_code)) w_state_next = RX_DATA;
            else                              w_state_next = RX_HS;
            if (i_eop) begin
              if (!pkt_is_token(w_pid_code) && !pkt_is_data(w_pid_code)) w_state_next = RX_DONE;
              else                                                        w_err = 1'b1;
            end
          end
        end else if (i_eop) begin
          w_err = 1'b1;
        end
      end
      RX_TOKEN: begin
        if (i_stuff_error) begin
          w_err = 1'b1;
        end else if (i_byte_ready && (r_tok_cnt == 2'd2)) begin
          w_err = 1'b1;
        end else if (i_eop) begin
          if (w_tok_after == 2'd2) w_state_next = RX_DONE;
          else                     w_err = 1'b1;
        end
      end
      RX_HS: begin
        if (i_stuff_error || i_byte_ready) w_err = 1'b1;
        else if (i_eop)                    w_state_next = RX_DONE;
      end
      RX_DATA: begin
        if (i_stuff_error) begin
          w_err = 1'b1;
        end else begin
          if (i_byte_ready && (r_hold_cnt == 2'd2)) begin
            w_write_due = 1'b1;
            if (r_pay_cnt == 7'(MAX_PAYLOAD)) w_err = 1'b1;
            else if (w_full)                  w_err = 1'b1;
          end
          if (!w_err && i_eop) begin
            if (w_hold_after != 2'd2) w_err = 1'b1;
            else if (!w_crc_ok)       w_err = 1'b1;
            else                      w_state_next = RX_DONE;
          end
        end
      end
      RX_DONE: begin
        w_state_next = RX_IDLE;
      end
      RX_ERR: begin
        if (i_eop) begin
          w_fin_err    = 1'b1;
          w_state_next = RX_IDLE;
        end
      end
      default: begin
        w_state_next = RX_IDLE;
      end
    endcase
    if (w_err) begin
      if (i_eop) begin
        w_fin_err    = 1'b1;
        w_state_next = RX_IDLE;
      end else begin
        w_state_next = RX_ERR;
      end
    end
  end

  // Output values for the next cycle; status levels hold until the next SYNC
  always_comb begin
    w_packet_next     = r_packet;
    w_data_ready_next = r_data_ready;
    w_active_next     = r_active;
    w_error_next      = r_error;
    w_store_next      = 1'b0;
    w_pdata_next      = r_pdata;
    w_flush_next      = 1'b0;
    if (w_sync_ok) begin
      w_packet_next     = PKT_NONE;
      w_data_ready_next = 1'b0;
      w_error_next      = 1'b0;
      w_active_next     = 1'b1;
    end
    if (w_pid_ok) w_packet_next = w_pid_code;
    if (w_write) begin
      w_store_next = 1'b1;
      w_pdata_next = r_hold0;
    end
    if (r_state == RX_DONE) begin
      w_data_ready_next = 1'b1;
      w_active_next     = 1'b0;
    end
    if (w_fin_err) begin
      w_error_next  = 1'b1;
      w_active_next = 1'b0;
      w_flush_next  = w_is_data;
    end
  end

  // Output and datapath registers
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_packet     <= PKT_NONE;
      r_data_ready <= 1'b0;
      r_active     <= 1'b0;
      r_error      <= 1'b0;
      r_store      <= 1'b0;
      r_pdata      <= '0;
      r_flush      <= 1'b0;
      r_hold0      <= '0;
      r_hold1      <= '0;
      r_hold_cnt   <= '0;
      r_tok_cnt    <= '0;
      r_pay_cnt    <= '0;
      r_is_data    <= 1'b0;
    end else begin
      r_packet     <= w_packet_next;
      r_data_ready <= w_data_ready_next;
      r_active     <= w_active_next;
      r_error      <= w_error_next;
      r_store      <= w_store_next;
      r_pdata      <= w_pdata_next;
      r_flush      <= w_flush_next;
      if (w_sync_ok) r_is_data <= 1'b0;
      if (w_pid_ok) begin
        r_is_data  <= pkt_is_data(w_pid_code);
        r_tok_cnt  <= '0;
        r_hold_cnt <= '0;
        r_pay_cnt  <= '0;
      end
      if ((r_state == RX_TOKEN) && i_byte_ready) r_tok_cnt <= w_tok_after;
      if (w_crc_en) begin
        r_hold0    <= r_hold1;
        r_hold1    <= i_rx_byte;
        r_hold_cnt <= w_hold_after;
      end
      if (w_write) r_pay_cnt <= r_pay_cnt + 7'd1;
    end
  end

  assign o_rx_packet            = r_packet;
  assign o_rx_data_ready        = r_data_ready;
  assign o_rx_transfer_active   = r_active;
  assign o_rx_error             = r_error;
  assign o_store_rx_packet_data = r_store;
  assign o_rx_packet_data       = r_pdata;
  assign o_rx_flush             = r_flush;

endmodule

// File: tb/tb_usb_rx_controller.sv
// Directed bench for usb_rx_controller: handshake, token, data with good
// and bad CRC, payload overflow, FIFO full, bad PID and mid-packet reset.
module tb_usb_rx_controller;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       byte_ready = 1'b0;
  logic [7:0] rx_byte = 8'h00;
  logic       eop = 1'b0;
  logic       stuff_error = 1'b0;
  logic [6:0] occupancy = 7'd0;
  logic [2:0] rx_packet;
  logic       rx_data_ready;
  logic       rx_active;
  logic       rx_error;
  logic       store;
  logic [7:0] pdata;
  logic       flush;

  int checks = 0;
  int errors = 0;
  int wr_cnt = 0;
  int flush_cnt = 0;
  logic [7:0] wr_mem [0:127];

  always #5 clk = ~clk;

  usb_rx_controller dut (
    .i_clk                  (clk),
    .i_rst                  (rst),
    .i_byte_ready           (byte_ready),
    .i_rx_byte              (rx_byte),
    .i_eop                  (eop),
    .i_stuff_error          (stuff_error),
    .i_buffer_occupancy     (occupancy),
    .o_rx_packet            (rx_packet),
    .o_rx_data_ready        (rx_data_ready),
    .o_rx_transfer_active   (rx_active),
    .o_rx_error             (rx_error),
    .o_store_rx_packet_data (store),
    .o_rx_packet_data       (pdata),
    .o_rx_flush             (flush)
  );

  // Record FIFO writes and flush pulses away from the active edge
  always @(negedge clk) begin
    if (store) begin
      if (wr_cnt < 128) wr_mem[wr_cnt] <= pdata;
      wr_cnt <= wr_cnt + 1;
    end
    if (flush) flush_cnt <= flush_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  // Called at a negedge; presents inputs for exactly one rising edge
  task automatic drive(input logic [7:0] b, input logic br, input logic e);
    rx_byte    = b;
    byte_ready = br;
    eop        = e;
    @(negedge clk);
    byte_ready = 1'b0;
    eop        = 1'b0;
  endtask

  task automatic send(input logic [7:0] b);
    drive(b, 1'b1, 1'b0);
  endtask

  task automatic send_eop();
    drive(8'h00, 1'b0, 1'b1);
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic clear_log();
    tick(2);
    wr_cnt    = 0;
    flush_cnt = 0;
  endtask

  // Reference CRC-16/USB: value to transmit (inverted), low byte sent first
  function automatic logic [15:0] usb_crc(input logic [7:0] d [], input int n);
    logic [15:0] c;
    c = 16'hFFFF;
    for (int k = 0; k < n; k++) begin
      c = c ^ {8'h00, d[k]};
      for (int j = 0; j < 8; j++) c = c[0] ? ((c >> 1) ^ 16'hA001) : (c >> 1);
    end
    return ~c;
  endfunction

  logic [7:0]  pay [];
  logic [15:0] crc;

  initial begin
    // Reset state
    tick(3);
    check("reset_packet", 32'(rx_packet), 32'd0);
    check("reset_ready",  32'(rx_data_ready), 32'd0);
    check("reset_active", 32'(rx_active), 32'd0);
    check("reset_error",  32'(rx_error), 32'd0);
    check("reset_store",  32'(store), 32'd0);
    check("reset_flush",  32'(flush), 32'd0);
    rst = 1'b0;
    tick(1);

    // 1: ACK handshake
    clear_log();
    send(8'h80);
    check("t1_active", 32'(rx_active), 32'd1);
    send(8'hD2);
    check("t1_packet", 32'(rx_packet), 32'd5);
    send_eop();
    check("t1_ready_early", 32'(rx_data_ready), 32'd0);
    tick(1);
    check("t1_ready", 32'(rx_data_ready), 32'd1);
    check("t1_active_end", 32'(rx_active), 32'd0);
    check("t1_error", 32'(rx_error), 32'd0);
    tick(1);
    check("t1_writes", 32'(wr_cnt), 32'd0);

    // 2: DATA0 01 02 03 with good CRC
    clear_log();
    pay = new[3];
    pay[0] = 8'h01; pay[1] = 8'h02; pay[2] = 8'h03;
    crc = usb_crc(pay, 3);
    send(8'h80); send(8'hC3);
    for (int i = 0; i < 3; i++) send(pay[i]);
    send(crc[7:0]); send(crc[15:8]);
    send_eop();
    tick(2);
    check("t2_writes", 32'(wr_cnt), 32'd3);
    check("t2_d0", 32'(wr_mem[0]), 32'h01);
    check("t2_d1", 32'(wr_mem[1]), 32'h02);
    check("t2_d2", 32'(wr_mem[2]), 32'h03);
    check("t2_packet", 32'(rx_packet), 32'd3);
    check("t2_ready", 32'(rx_data_ready), 32'd1);
    check("t2_error", 32'(rx_error), 32'd0);
    check("t2_flush", 32'(flush_cnt), 32'd0);

    // 2b: DATA1 single byte, last CRC byte coincides with EOP
    clear_log();
    pay = new[1];
    pay[0] = 8'hAA;
    crc = usb_crc(pay, 1);
    send(8'h80); send(8'h4B); send(8'hAA); send(crc[7:0]);
    drive(crc[15:8], 1'b1, 1'b1);
    tick(2);
    check("t2b_writes", 32'(wr_cnt), 32'd1);
    check("t2b_d0", 32'(wr_mem[0]), 32'hAA);
    check("t2b_packet", 32'(rx_packet), 32'd4);
    check("t2b_ready", 32'(rx_data_ready), 32'd1);
    check("t2b_error", 32'(rx_error), 32'd0);

    // 3: DATA0 01 02 03 with one CRC bit flipped
    clear_log();
    pay = new[3];
    pay[0] = 8'h01; pay[1] = 8'h02; pay[2] = 8'h03;
    crc = usb_crc(pay, 3) ^ 16'h0010;
    send(8'h80); send(8'hC3);
    for (int i = 0; i < 3; i++) send(pay[i]);
    send(crc[7:0]); send(crc[15:8]);
    send_eop();
    tick(2);
    check("t3_writes", 32'(wr_cnt), 32'd3);
    check("t3_flush", 32'(flush_cnt), 32'd1);
    check("t3_error", 32'(rx_error), 32'd1);
    check("t3_ready", 32'(rx_data_ready), 32'd0);
    check("t3_packet", 32'(rx_packet), 32'd3);

    // 4: DATA1 with 65 payload bytes; error held from test 3 clears at SYNC
    clear_log();
    send(8'h80);
    check("t4_err_cleared", 32'(rx_error), 32'd0);
    send(8'h4B);
    for (int i = 0; i < 65; i++) send(8'(i + 1));
    check("t4_active_mid", 32'(rx_active), 32'd1);
    send(8'h12); send(8'h34);
    send_eop();
    tick(2);
    check("t4_writes", 32'(wr_cnt), 32'd64);
    check("t4_first", 32'(wr_mem[0]), 32'h01);
    check("t4_last", 32'(wr_mem[63]), 32'h40);
    check("t4_error", 32'(rx_error), 32'd1);
    check("t4_flush", 32'(flush_cnt), 32'd1);
    check("t4_packet", 32'(rx_packet), 32'd4);

    // 5a: OUT token with full FIFO, truncated by EOP
    clear_log();
    occupancy = 7'd64;
    send(8'h80); send(8'hE1);
    send_eop();
    tick(2);
    check("t5a_writes", 32'(wr_cnt), 32'd0);
    check("t5a_error", 32'(rx_error), 32'd1);
    check("t5a_packet", 32'(rx_packet), 32'd1);
    check("t5a_flush", 32'(flush_cnt), 32'd0);

    // 5c: DATA0 with full FIFO when the first write is due
    clear_log();
    send(8'h80); send(8'hC3);
    send(8'h01); send(8'h02); send(8'h03);
    send_eop();
    tick(2);
    check("t5c_writes", 32'(wr_cnt), 32'd0);
    check("t5c_error", 32'(rx_error), 32'd1);
    check("t5c_flush", 32'(flush_cnt), 32'd1);
    occupancy = 7'd0;

    // 5b: bad PID check nibble
    clear_log();
    send(8'h80); send(8'hD3);
    send_eop();
    tick(2);
    check("t5b_error", 32'(rx_error), 32'd1);
    check("t5b_packet", 32'(rx_packet), 32'd0);
    check("t5b_ready", 32'(rx_data_ready), 32'd0);

    // 5d: IN token with two bytes completes cleanly
    clear_log();
    send(8'h80); send(8'h69); send(8'h81); send(8'h58);
    send_eop();
    tick(2);
    check("t5d_packet", 32'(rx_packet), 32'd2);
    check("t5d_ready", 32'(rx_data_ready), 32'd1);
    check("t5d_writes", 32'(wr_cnt), 32'd0);

    // 6: reset in the middle of a data payload
    clear_log();
    send(8'h80); send(8'hC3);
    send(8'h01); send(8'h02); send(8'h03); send(8'h04);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    check("t6_packet", 32'(rx_packet), 32'd0);
    check("t6_active", 32'(rx_active), 32'd0);
    check("t6_error", 32'(rx_error), 32'd0);
    check("t6_store", 32'(store), 32'd0);
    send(8'h05); send(8'h06);
    tick(2);
    check("t6_writes", 32'(wr_cnt), 32'd2);
    check("t6_idle_packet", 32'(rx_packet), 32'd0);
    send(8'h80); send(8'hD2);
    send_eop();
    tick(2);
    check("t6_ack_packet", 32'(rx_packet), 32'd5);
    check("t6_ack_ready", 32'(rx_data_ready), 32'd1);
    check("t6_ack_error", 32'(rx_error), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
